// File: rtl/stream_line_packer_pkg.sv
// Shared widths, FSM state encoding and lane index type for the stream line packer.
package stream_line_packer_pkg;

  localparam int LINE_W = 128;
  localparam int LANE_W = 32;
  localparam int BE_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/stream_line_assembler.sv
// Collects 32-bit words into a 128-bit line with a matching byteenable mask.
module stream_line_assembler
  import stream_line_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [LANE_W-1:0] data_i,
  output lane_idx_t         lane_idx_o,
  output logic [LINE_W-1:0] line_o,
  output logic [BE_W-1:0]   be_o
);

  lane_idx_t         idx_q,  idx_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BE_W-1:0]   be_q,   be_d;

  // NOTE: every combinational output gets a default first so no path holds a stale value (no latch).
  always_comb begin
    idx_d  = idx_q;
    line_d = line_q;
    be_d   = be_q;
    if (clear_i) begin
      idx_d  = '0;
      line_d = '0;
      be_d   = '0;
    end else if (accept_i) begin
      line_d[{idx_q, 5'd0} +: LANE_W] = data_i;
      be_d[{idx_q, 2'd0} +: 4]        = 4'hF;
      idx_d                           = idx_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      line_q <= '0;
      be_q   <= '0;
    end else begin
      idx_q  <= idx_d;
      line_q <= line_d;
      be_q   <= be_d;
    end
  end

  assign lane_idx_o = idx_q;
  assign line_o     = line_q;
  assign be_o       = be_q;

endmodule

// File: rtl/stream_line_packer.sv
// Packs a 32-bit word stream into 128-bit lines written to consecutive RAM line addresses.
module stream_line_packer
  import stream_line_packer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_data,
  input  logic              in_eop,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_writedata,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W:0]   lines_written
);

  localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   lines_q, lines_d;
  logic              wrapped_q, wrapped_d;
  logic              eop_seen_q, eop_seen_d;
  logic              in_ready_q, busy_q, done_q, mem_we_q;

  logic              asm_clear, asm_accept;
  lane_idx_t         lane_idx;

  stream_line_assembler u_assembler (
    .clk        (clk),
    .rst_n      (reset_n),
    .clear_i    (asm_clear),
    .accept_i   (asm_accept),
    .data_i     (in_data),
    .lane_idx_o (lane_idx),
    .line_o     (mem_writedata),
    .be_o       (mem_byteenable)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lines_d    = lines_q;
    wrapped_d  = wrapped_q;
    eop_seen_d = eop_seen_q;
    asm_clear  = 1'b0;
    asm_accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d    = FILL;
          addr_d     = start_addr;
          lines_d    = '0;
          wrapped_d  = 1'b0;
          eop_seen_d = 1'b0;
          asm_clear  = 1'b1;
        end
      end
      FILL: begin
        if (abort) begin
          state_d   = IDLE;
          asm_clear = 1'b1;
        end else if (in_valid) begin
          asm_accept = 1'b1;
          eop_seen_d = in_eop;
          if (in_eop || lane_idx == LAST_LANE) state_d = WRITE;
        end
      end
      WRITE: begin
        // the line is on the bus this cycle; the assembler is cleared for the next one
        asm_clear = 1'b1;
        addr_d    = addr_q + 1'b1;
        if (&addr_q)          wrapped_d = 1'b1;
        if (!lines_q[ADDR_W]) lines_d   = lines_q + 1'b1;
        if (abort)           state_d = IDLE;
        else if (eop_seen_q) state_d = DONE;
        else                 state_d = FILL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status and strobe flops are loaded from the next state so the outputs line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      lines_q    <= '0;
      wrapped_q  <= 1'b0;
      eop_seen_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lines_q    <= lines_d;
      wrapped_q  <= wrapped_d;
      eop_seen_q <= eop_seen_d;
      in_ready_q <= (state_d == FILL);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      mem_we_q   <= (state_d == WRITE);
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_chipselect = mem_we_q;
  assign mem_write      = mem_we_q;
  assign mem_address    = addr_q;
  assign wrapped        = wrapped_q;
  assign lines_written  = lines_q;

endmodule

// File: tb/tb_stream_line_packer.sv
// Self-checking bench: table-driven transfers with a write scoreboard plus abort/reset sequences.
module tb_stream_line_packer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [7:0]   start_addr;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_eop;
  logic [7:0]   mem_address;
  logic [15:0]  mem_byteenable;
  logic         mem_chipselect;
  logic         mem_write;
  logic [127:0] mem_writedata;
  logic         busy;
  logic         done;
  logic         wrapped;
  logic [8:0]   lines_written;

  stream_line_packer #(.ADDR_W(8), .LANES(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .start_addr     (start_addr),
    .abort          (abort),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_eop         (in_eop),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .busy           (busy),
    .done           (done),
    .wrapped        (wrapped),
    .lines_written  (lines_written)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]   addr;
    logic [127:0] data;
    logic [15:0]  be;
  } wr_t;

  wr_t sb[$];

  logic [127:0] m_line;
  logic [15:0]  m_be;
  int           m_k;
  logic [7:0]   m_addr;

  task automatic model_start(input logic [7:0] a);
    m_addr = a;
    m_k    = 0;
    m_line = '0;
    m_be   = '0;
  endtask

  task automatic model_accept(input logic [31:0] d, input bit eop);
    m_line[m_k*32 +: 32] = d;
    m_be[m_k*4 +: 4]     = 4'hF;
    m_k++;
    if (m_k == 4 || eop) begin
      sb.push_back('{m_addr, m_line, m_be});
      m_addr = m_addr + 8'd1;
      m_k    = 0;
      m_line = '0;
      m_be   = '0;
    end
  endtask

  // Write monitor: every write strobe must match the oldest expected line.
  always @(negedge clk) begin
    if (reset_n && mem_write) begin
      check("write_expected", 128'(sb.size() != 0), 128'd1);
      check("ready_low_in_write", in_ready, 1'b0);
      check("chipselect_in_write", mem_chipselect, 1'b1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", mem_address, e.addr);
        check("wr_data", mem_writedata, e.data);
        check("wr_be", mem_byteenable, e.be);
      end
    end
  end

  typedef struct {
    logic [7:0]  addr;
    int          n;
    logic [31:0] base;
    bit          rnd;
    logic [8:0]  exp_lines;
    bit          exp_wrap;
  } vec_t;

  vec_t vecs[6];

  task automatic do_start(input logic [7:0] a);
    start      = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    model_start(a);
  endtask

  task automatic drive_words(input int n, input logic [31:0] base, input bit rnd, input bit last_eop);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 400) begin
      logic [31:0] d;
      bit e, hs;
      d        = base + 32'(i);
      e        = last_eop && (i == n - 1);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = d;
      in_eop   = e;
      hs       = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        model_accept(d, e);
        i++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_eop   = 1'b0;
    if (i < n) check("words_accepted", i, n);
  endtask

  task automatic wait_end(input logic [8:0] exp_lines, input bit exp_wrap);
    int n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done, 1'b1);
    if (done) begin
      check("busy_with_done", busy, 1'b1);
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);
      check("busy_after_done", busy, 1'b0);
    end
    check("lines_written", lines_written, exp_lines);
    check("wrapped", wrapped, exp_wrap);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h10, 8, 32'h1,        1'b0, 9'd2, 1'b0};
    vecs[1] = '{8'h20, 1, 32'hA5A5A5A5, 1'b0, 9'd1, 1'b0};
    vecs[2] = '{8'hFF, 8, 32'h100,      1'b0, 9'd2, 1'b1};
    vecs[3] = '{8'h00, 6, 32'h200,      1'b1, 9'd2, 1'b0};
    vecs[4] = '{8'h40, 3, 32'h300,      1'b0, 9'd1, 1'b0};
    vecs[5] = '{8'hFE, 5, 32'h400,      1'b1, 9'd2, 1'b1};

    reset_n = 1'b0; start = 1'b0; start_addr = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; in_eop = 1'b0;
    model_start(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_lines", lines_written, 9'd0);
    check("rst_writedata", mem_writedata, 128'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].addr);
      check("busy_after_start", busy, 1'b1);
      drive_words(vecs[v].n, vecs[v].base, vecs[v].rnd, 1'b1);
      wait_end(vecs[v].exp_lines, vecs[v].exp_wrap);
      @(posedge clk); #1;
    end

    // abort in FILL after two accepted words: no write, no done
    do_start(8'h30);
    drive_words(2, 32'h500, 1'b0, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_fill_busy", busy, 1'b0);
    check("abort_fill_ready", in_ready, 1'b0);
    check("abort_fill_lines", lines_written, 9'd0);
    for (int c = 0; c < 3; c++) begin
      check("abort_fill_no_done", done, 1'b0);
      @(posedge clk); #1;
    end
    model_start(8'h00);

    // abort during the write cycle: write completes, then IDLE without done
    do_start(8'h50);
    drive_words(4, 32'h600, 1'b0, 1'b0);
    check("write_cycle", mem_write, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_wr_busy", busy, 1'b0);
    check("abort_wr_done", done, 1'b0);
    check("abort_wr_lines", lines_written, 9'd1);
    check("abort_wr_addr", mem_address, 8'h51);
    check("abort_wr_sb", sb.size(), 0);
    @(posedge clk); #1;
    check("abort_wr_no_done", done, 1'b0);

    // abort has priority over start in IDLE
    start = 1'b1; abort = 1'b1; start_addr = 8'h99;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 1'b0);
    check("abort_start_lines", lines_written, 9'd1);

    // asynchronous reset mid-FILL
    do_start(8'h60);
    drive_words(2, 32'h700, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_addr", mem_address, 8'h00);
    check("mid_rst_data", mem_writedata, 128'd0);
    check("mid_rst_be", mem_byteenable, 16'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_start(8'h00);
    @(posedge clk); #1;
    check("post_rst_no_write", mem_write, 1'b0);

    do_start(vecs[0].addr);
    drive_words(vecs[0].n, vecs[0].base, 1'b0, 1'b1);
    wait_end(vecs[0].exp_lines, vecs[0].exp_wrap);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_line_packer.md
STREAM_LINE_PACKER -- requirements
Module: stream_line_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the memory word-address width.
REQ-002 SHALL have parameter LANES, default 4, the number of 32-bit lanes per 128-bit line; it is fixed at 4 in this revision.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have ports start (input, 1) and start_addr (input, ADDR_W), which begin a transfer at that line address.
REQ-006 SHALL have port abort, input, 1, a synchronous cancel of the current transfer.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 32) and in_eop (input, 1), forming an Avalon-ST style word stream.
REQ-008 SHALL have ports mem_address (output, ADDR_W), mem_byteenable (output, 16), mem_chipselect (output, 1), mem_write (output, 1) and mem_writedata (output, 128), which drive the 128-bit on-chip RAM slave.
REQ-009 SHALL have ports busy (output, 1), done (output, 1), wrapped (output, 1) and lines_written (output, ADDR_W+1).

Function
REQ-010 SHALL implement the FSM states IDLE, FILL, WRITE and DONE.
REQ-011 In IDLE, start SHALL latch start_addr, clear the lane index, byteenable accumulator, lines_written and wrapped, and go to FILL; start outside IDLE SHALL be ignored.
REQ-012 in_ready SHALL be 1 only in FILL; a word is accepted on a cycle with in_valid&in_ready.
REQ-013 An accepted word SHALL be placed in lane k, bits 32k+31:32k, and SHALL set byteenable bits 4k+3:4k, where k is the lane index (0..3).
REQ-014 FILL SHALL go to WRITE on accepting lane 3 or on accepting a word with in_eop=1, whichever occurs first.
REQ-015 WRITE SHALL last exactly one cycle with mem_chipselect=1, mem_write=1, the assembled line, the accumulated byteenable and the current address; unfilled lanes SHALL be zero.
REQ-016 After WRITE: lines_written SHALL increment; the address SHALL increment modulo 2^ADDR_W; the lane state SHALL clear; the next state SHALL be DONE if eop was accepted, else FILL.
REQ-017 An address step from 2^ADDR_W-1 to 0 SHALL set wrapped, which stays sticky until the next start.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 busy SHALL be 1 in FILL, WRITE and DONE.
REQ-020 Latency: the write cycle SHALL follow the accepting cycle of the last lane by one clock; sustained throughput is 4 words per 5 cycles.
REQ-021 abort in FILL SHALL discard the partial line with no write, go to IDLE, and leave done=0.
REQ-022 abort in WRITE SHALL let the write complete, then go to IDLE with done=0.
REQ-023 Simultaneous abort and start in IDLE SHALL give abort priority; the block stays in IDLE.
REQ-024 mem_chipselect and mem_write SHALL be 0 in every state except WRITE; mem_writedata, mem_byteenable and mem_address are don't-care when not writing but SHALL be registered.
REQ-025 lines_written SHALL saturate at 2^ADDR_W.

Reset
REQ-026 reset_n low SHALL asynchronously force: state IDLE; in_ready, mem_chipselect, mem_write, busy, done and wrapped to 0; mem_address, mem_byteenable, mem_writedata and lines_written to 0; lane index and accumulator to 0.
REQ-027 Reset asserted mid-transfer SHALL drop any partial line, and no write SHALL occur on the cycle following deassertion.

Structure
REQ-028 A shared package SHALL hold LINE_W=128, LANE_W=32, BE_W=16, the state enum and the lane index type.
REQ-029 One sub-module, stream_line_assembler, SHALL hold the lane registers, lane index and byteenable accumulator; the FSM, address counter and status logic SHALL stay in the top level.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 start_addr=0x10 with 8 words 0x1..0x8, eop on word 8 -> two writes: addr 0x10 data {4,3,2,1} BE 0xFFFF and addr 0x11 data {8,7,6,5} BE 0xFFFF; one-cycle done; lines_written=2.
REQ-032 A single word 0xA5A5A5A5 with eop -> one write with BE 0x000F, data 0x...A5A5A5A5 with upper lanes zero; done.
REQ-033 start_addr=0xFF with 8 words -> writes at 0xFF and then 0x00; wrapped=1.
REQ-034 abort after 2 words accepted -> no write; IDLE; done stays 0; busy falls the next cycle.
REQ-035 in_valid toggling randomly with 6 words and eop on word 6 -> lines 0x0 (BE 0xFFFF) and 0x1 (BE 0x00FF); in_ready=0 during each WRITE.
REQ-036 reset_n pulsed low mid-FILL -> all outputs 0 immediately; a subsequent start works normally.
